// File: rtl/aes_pkg.sv
// Shared widths, legal key sizes and packer state encoding for the AES
// front-end blocks.
package aes_pkg;

  localparam int AES_BLOCK_W    = 128;
  localparam int AES_WORD_W     = 32;
  localparam int AES_DATA_WORDS = AES_BLOCK_W / AES_WORD_W;

  localparam int AES_KEY_WORDS_128 = 4;
  localparam int AES_KEY_WORDS_192 = 6;
  localparam int AES_KEY_WORDS_256 = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } packer_state_e;

  function automatic bit key_words_legal(input int kw);
    return (kw == AES_KEY_WORDS_128) || (kw == AES_KEY_WORDS_192) ||
           (kw == AES_KEY_WORDS_256);
  endfunction

endpackage

// File: rtl/aes_word_assembler.sv
// N-word slot register: stores the first N-1 words and presents them merged
// with the incoming word so the final word can be consumed on its own edge.
module aes_word_assembler
  import aes_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = AES_WORD_W,
  parameter int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr_i,
  input  logic           wr_i,
  input  logic [W-1:0]   word_i,
  output logic [N*W-1:0] assembled_o,
  output logic           wrap_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          last;

  assign last   = (cnt_q == CW'(N - 1));
  assign wrap_o = wr_i && !clr_i && last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wr_i) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The last slot is never stored: the final word goes straight to the output.
  genvar gi;
  generate
    for (gi = 0; gi < N - 1; gi++) begin : g_slot
      logic [W-1:0] slot_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_q <= '0;
        end else if (wr_i && !clr_i && (cnt_q == CW'(gi))) begin
          slot_q <= word_i;
        end
      end

      assign assembled_o[(N-gi)*W-1 -: W] = slot_q;
    end
  endgenerate

  assign assembled_o[W-1:0] = word_i;

endmodule

// File: rtl/aes_block_packer.sv
// Packs a tagged 32-bit key/data word stream into 128-bit blocks paired with
// a snapshot of the committed key, handed off over a valid/ready stage.
module aes_block_packer
  import aes_pkg::*;
#(
  parameter int KEY_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [AES_WORD_W-1:0]         in_word,
  input  logic                          in_is_key,
  input  logic                          in_flush,
  output logic                          blk_valid,
  input  logic                          blk_ready,
  output logic [AES_BLOCK_W-1:0]        blk_data,
  output logic [AES_WORD_W*KEY_WORDS-1:0] blk_key,
  output logic                          key_valid,
  output logic                          err_no_key
);

  localparam int KEY_W = AES_WORD_W * KEY_WORDS;

  generate
    if (!key_words_legal(KEY_WORDS)) begin : g_illegal_key_words
      $error("aes_block_packer: KEY_WORDS must be 4, 6 or 8");
    end
  endgenerate

  packer_state_e          state_q;
  logic [KEY_W-1:0]       key_q;
  logic                   key_valid_q;
  logic [AES_BLOCK_W-1:0] blk_data_q;
  logic [KEY_W-1:0]       blk_key_q;
  logic                   err_q;

  logic                   accept;
  logic                   key_wr;
  logic                   data_word;
  logic                   data_wr;
  logic [KEY_W-1:0]       key_full;
  logic                   key_commit;
  logic [AES_BLOCK_W-1:0] data_full;
  logic                   blk_done;

  // A flush in the same cycle wins over the word, so the word never lands.
  assign accept    = in_valid && (state_q == COLLECT);
  assign key_wr    = accept && in_is_key && !in_flush;
  assign data_word = accept && !in_is_key && !in_flush;
  assign data_wr   = data_word && key_valid_q;

  aes_word_assembler #(
    .N (KEY_WORDS),
    .W (AES_WORD_W)
  ) u_key_stage (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (in_flush),
    .wr_i        (key_wr),
    .word_i      (in_word),
    .assembled_o (key_full),
    .wrap_o      (key_commit)
  );

  aes_word_assembler #(
    .N (AES_DATA_WORDS),
    .W (AES_WORD_W)
  ) u_data_stage (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (in_flush),
    .wr_i        (data_wr),
    .word_i      (in_word),
    .assembled_o (data_full),
    .wrap_o      (blk_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      blk_data_q  <= '0;
      blk_key_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= data_word && !key_valid_q;
      if (key_commit) begin
        key_q       <= key_full;
        key_valid_q <= 1'b1;
      end
      case (state_q)
        COLLECT: begin
          if (blk_done) begin
            blk_data_q <= data_full;
            blk_key_q  <= key_q;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (blk_ready) begin
            state_q <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign in_ready   = (state_q == COLLECT);
  assign blk_valid  = (state_q == HOLD);
  assign blk_data   = blk_data_q;
  assign blk_key    = blk_key_q;
  assign key_valid  = key_valid_q;
  assign err_no_key = err_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Scoreboard bench for aes_block_packer: AES-128 instance for the main flows,
// AES-256 instance for the wide-key load.
`timescale 1ns/1ps
module tb_aes_block_packer;

  localparam logic [127:0] KEY1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2    = 128'ha0a1a2a3b0b1b2b3c0c1c2c3d0d1d2d3;
  localparam logic [127:0] K3    = 128'h55555555666666667777777788888888;
  localparam logic [127:0] DATA1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] DATA2 = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] DATA3 = 128'h11111111222222223333333344444444;
  localparam logic [127:0] DATA4 = 128'hcafef00ddeadbeef0badc0de12345678;
  localparam logic [255:0] KEY256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_is_key = 1'b0, in_flush = 1'b0, blk_ready = 1'b0;
  logic [31:0]  in_word = '0;
  logic         in_ready, blk_valid, key_valid, err_no_key;
  logic [127:0] blk_data, blk_key;

  logic         in_valid8 = 1'b0, in_is_key8 = 1'b0, in_flush8 = 1'b0, blk_ready8 = 1'b0;
  logic [31:0]  in_word8 = '0;
  logic         in_ready8, blk_valid8, key_valid8, err_no_key8;
  logic [127:0] blk_data8;
  logic [255:0] blk_key8;

  aes_block_packer #(.KEY_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .in_is_key(in_is_key), .in_flush(in_flush),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_key(blk_key), .key_valid(key_valid), .err_no_key(err_no_key)
  );

  aes_block_packer #(.KEY_WORDS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_word(in_word8), .in_is_key(in_is_key8), .in_flush(in_flush8),
    .blk_valid(blk_valid8), .blk_ready(blk_ready8), .blk_data(blk_data8),
    .blk_key(blk_key8), .key_valid(key_valid8), .err_no_key(err_no_key8)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [127:0] data;
    logic [127:0] key;
  } blk_t;

  blk_t exp_q[$];
  blk_t mon_e;
  int   pop_cyc[$];

  // Handshake monitor: every accepted block must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && blk_valid && blk_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL block_unexpected got data=%h key=%h, none required", blk_data, blk_key);
      end else begin
        mon_e = exp_q.pop_front();
        if (blk_data !== mon_e.data || blk_key !== mon_e.key) begin
          n_err++;
          $display("FAIL block_content got data=%h key=%h required data=%h key=%h",
                   blk_data, blk_key, mon_e.data, mon_e.key);
        end else begin
          $display("block ok data=%h key=%h @cyc %0d", blk_data, blk_key, cyc);
        end
      end
      pop_cyc.push_back(cyc);
    end
  end

  task automatic drive(input logic [31:0] w, input logic k);
    int t;
    t = 0;
    in_valid  = 1'b1;
    in_word   = w;
    in_is_key = k;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    n_cmp++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL drive_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_key(input logic [127:0] k);
    for (int i = 0; i < 4; i++) drive(k[127-32*i -: 32], 1'b1);
  endtask

  task automatic send_data(input logic [127:0] d);
    for (int i = 0; i < 4; i++) drive(d[127-32*i -: 32], 1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (blk_valid !== 1'b0) begin n_err++; $display("FAIL reset_blk_valid got=%b want=0", blk_valid); end
    n_cmp++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_key_valid got=%b want=0", key_valid); end
    n_cmp++; if (err_no_key !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b want=0", err_no_key); end
    n_cmp++; if (blk_data !== 128'h0) begin n_err++; $display("FAIL reset_blk_data got=%h want=0", blk_data); end
    n_cmp++; if (blk_key !== 128'h0) begin n_err++; $display("FAIL reset_blk_key got=%h want=0", blk_key); end
    n_cmp++; if (key_valid8 !== 1'b0 || err_no_key8 !== 1'b0) begin n_err++; $display("FAIL reset_dut8 got key_valid=%b err=%b want 0/0", key_valid8, err_no_key8); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_basic;
    blk_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(KEY1[127-32*i -: 32], 1'b1);
      n_cmp++;
      if (key_valid !== (i == 3)) begin n_err++; $display("FAIL basic_key_valid word%0d got=%b want=%b", i, key_valid, (i == 3)); end
    end
    exp_q.push_back({DATA1, KEY1});
    send_data(DATA1);
    n_cmp++; if (blk_valid !== 1'b1) begin n_err++; $display("FAIL basic_blk_valid got=%b want=1", blk_valid); end
    @(posedge clk); #1;
    n_cmp++; if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL basic_one_cycle got valid=%b ready=%b want 0/1", blk_valid, in_ready); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL basic_pending got=%0d want=0", exp_q.size()); end
    $display("test_basic done");
  endtask

  task automatic test_no_key;
    rst_n = 1'b0; #2;
    @(posedge clk); #1;
    rst_n = 1'b1;
    blk_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(32'h00112233, 1'b0);
      n_cmp++; if (err_no_key !== 1'b1) begin n_err++; $display("FAIL nokey_err_pulse word%0d got=%b want=1", i, err_no_key); end
      @(posedge clk); #1;
      n_cmp++; if (err_no_key !== 1'b0 || blk_valid !== 1'b0) begin n_err++; $display("FAIL nokey_after word%0d got err=%b valid=%b want 0/0", i, err_no_key, blk_valid); end
    end
    send_key(KEY1);
    exp_q.push_back({DATA1, KEY1});
    for (int i = 0; i < 3; i++) drive(DATA1[127-32*i -: 32], 1'b0);
    n_cmp++; if (blk_valid !== 1'b0) begin n_err++; $display("FAIL nokey_early_block got=%b want=0", blk_valid); end
    drive(DATA1[31:0], 1'b0);
    n_cmp++; if (blk_valid !== 1'b1) begin n_err++; $display("FAIL nokey_block got=%b want=1", blk_valid); end
    @(posedge clk); #1;
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL nokey_pending got=%0d want=0", exp_q.size()); end
    $display("test_no_key done");
  endtask

  task automatic test_backpressure;
    blk_ready = 1'b0;
    exp_q.push_back({DATA2, KEY1});
    send_data(DATA2);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (blk_valid !== 1'b1 || in_ready !== 1'b0 || blk_data !== DATA2 || blk_key !== KEY1) begin
        n_err++;
        $display("FAIL hold_stable cyc%0d got valid=%b ready=%b data=%h key=%h want 1/0/%h/%h",
                 i, blk_valid, in_ready, blk_data, blk_key, DATA2, KEY1);
      end
      if (i == 1) begin in_valid = 1'b1; in_word = 32'hdeadbeef; in_is_key = 1'b0; end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    blk_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin n_err++; $display("FAIL hold_release got ready=%b valid=%b want 1/0", in_ready, blk_valid); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL hold_pending got=%0d want=0", exp_q.size()); end
    $display("test_backpressure done");
  endtask

  task automatic test_rekey;
    blk_ready = 1'b1;
    exp_q.push_back({DATA3, K2});
    drive(DATA3[127:96], 1'b0);
    drive(DATA3[95:64], 1'b0);
    send_key(K2);
    drive(DATA3[63:32], 1'b0);
    drive(DATA3[31:0], 1'b0);
    n_cmp++; if (blk_valid !== 1'b1 || blk_key !== K2) begin n_err++; $display("FAIL rekey_key got valid=%b key=%h want 1/%h", blk_valid, blk_key, K2); end
    @(posedge clk); #1;
    drive(32'h0badf00d, 1'b0);
    drive(K3[127:96], 1'b1);
    drive(K3[95:64], 1'b1);
    in_flush = 1'b1; in_valid = 1'b1; in_word = 32'hbad0bad0; in_is_key = 1'b0;
    @(posedge clk); #1;
    in_flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (key_valid !== 1'b1) begin n_err++; $display("FAIL flush_key_valid got=%b want=1", key_valid); end
    exp_q.push_back({DATA4, K2});
    send_data(DATA4);
    n_cmp++; if (blk_data !== DATA4 || blk_key !== K2) begin n_err++; $display("FAIL flush_block got data=%h key=%h want %h/%h", blk_data, blk_key, DATA4, K2); end
    @(posedge clk); #1;
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rekey_pending got=%0d want=0", exp_q.size()); end
    $display("test_rekey done");
  endtask

  task automatic test_back_to_back;
    blk_ready = 1'b1;
    pop_cyc.delete();
    exp_q.push_back({DATA1, K2});
    exp_q.push_back({DATA2, K2});
    send_data(DATA1);
    send_data(DATA2);
    @(posedge clk); #1;
    n_cmp++;
    if (pop_cyc.size() != 2) begin
      n_err++;
      $display("FAIL b2b_count got=%0d want=2", pop_cyc.size());
    end else if (pop_cyc[1] - pop_cyc[0] != 5) begin
      n_err++;
      $display("FAIL b2b_period got=%0d want=5", pop_cyc[1] - pop_cyc[0]);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_pending got=%0d want=0", exp_q.size()); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid;
    blk_ready = 1'b0;
    send_data(DATA3);
    n_cmp++; if (blk_valid !== 1'b1) begin n_err++; $display("FAIL rmid_hold got=%b want=1", blk_valid); end
    rst_n = 1'b0; #1;
    n_cmp++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b1 || key_valid !== 1'b0 || blk_data !== 128'h0 ||
        blk_key !== 128'h0 || err_no_key !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_outputs got valid=%b ready=%b kv=%b data=%h key=%h err=%b want reset values",
               blk_valid, in_ready, key_valid, blk_data, blk_key, err_no_key);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drive(K3[127-32*i -: 32], 1'b1);
    rst_n = 1'b0; #1;
    n_cmp++; if (key_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_partial got kv=%b ready=%b want 0/1", key_valid, in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    blk_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(KEY1[127-32*i -: 32], 1'b1);
      n_cmp++;
      if (key_valid !== (i == 3)) begin n_err++; $display("FAIL rmid_key_valid word%0d got=%b want=%b", i, key_valid, (i == 3)); end
    end
    exp_q.push_back({DATA1, KEY1});
    send_data(DATA1);
    @(posedge clk); #1;
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rmid_pending got=%0d want=0", exp_q.size()); end
    $display("test_reset_mid done");
  endtask

  task automatic test_key256;
    blk_ready8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL k256_ready word%0d got=%b want=1", i, in_ready8); end
      in_valid8 = 1'b1; in_is_key8 = 1'b1; in_word8 = KEY256[255-32*i -: 32];
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      n_cmp++;
      if (key_valid8 !== (i == 7)) begin n_err++; $display("FAIL k256_key_valid word%0d got=%b want=%b", i, key_valid8, (i == 7)); end
    end
    for (int i = 0; i < 4; i++) begin
      in_valid8 = 1'b1; in_is_key8 = 1'b0; in_word8 = DATA1[127-32*i -: 32];
      @(posedge clk); #1;
      in_valid8 = 1'b0;
    end
    n_cmp++;
    if (blk_valid8 !== 1'b1 || blk_data8 !== DATA1 || blk_key8 !== KEY256) begin
      n_err++;
      $display("FAIL k256_block got valid=%b data=%h key=%h want 1/%h/%h", blk_valid8, blk_data8, blk_key8, DATA1, KEY256);
    end
    @(posedge clk); #1;
    n_cmp++; if (blk_valid8 !== 1'b0 || err_no_key8 !== 1'b0) begin n_err++; $display("FAIL k256_release got valid=%b err=%b want 0/0", blk_valid8, err_no_key8); end
    $display("test_key256 done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_key();
    test_backpressure();
    test_rekey();
    test_back_to_back();
    test_reset_mid();
    test_key256();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
